// File: rtl/pmem_fetch_cache.sv
// Direct-mapped read-only instruction cache between a core fetcher and one program-memory
// controller slot, using the same 4-phase valid/ready read handshake on both faces.
module pmem_fetch_cache #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 fetch_read_valid,
    input  logic [ADDR_BITS-1:0] fetch_read_address,
    output logic                 fetch_read_ready,
    output logic [DATA_BITS-1:0] fetch_read_data,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic [CNT_BITS-1:0]  hit_count,
    output logic [CNT_BITS-1:0]  miss_count
);

    localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
    localparam int unsigned TAG_BITS = ADDR_BITS - IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StMissWait, StMissDrop, StRespond} state_e;

    state_e                 state_q, state_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_q  [NUM_LINES];
    logic [TAG_BITS-1:0]    tag_d  [NUM_LINES];
    logic [DATA_BITS-1:0]   data_q [NUM_LINES];
    logic [DATA_BITS-1:0]   data_d [NUM_LINES];
    logic                   fetch_read_ready_q, fetch_read_ready_d;
    logic [DATA_BITS-1:0]   fetch_read_data_q, fetch_read_data_d;
    logic                   mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
    logic [DATA_BITS-1:0]   fill_data_q, fill_data_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [CNT_BITS-1:0]    hit_count_q, hit_count_d;
    logic [CNT_BITS-1:0]    miss_count_q, miss_count_d;

    logic [IDX_BITS-1:0]    req_idx, fill_idx;
    logic [TAG_BITS-1:0]    req_tag, fill_tag;
    logic                   req_hit;
    logic                   install;

    assign req_idx  = fetch_read_address[IDX_BITS-1:0];
    assign req_tag  = fetch_read_address[ADDR_BITS-1:IDX_BITS];
    // The miss address register stays stable through the fill, so it indexes the install.
    assign fill_idx = mem_read_address_q[IDX_BITS-1:0];
    assign fill_tag = mem_read_address_q[ADDR_BITS-1:IDX_BITS];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d            = state_q;
        valid_d            = valid_q;
        tag_d              = tag_q;
        data_d             = data_q;
        fetch_read_ready_d = fetch_read_ready_q;
        fetch_read_data_d  = fetch_read_data_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        fill_data_d        = fill_data_q;
        flush_pend_d       = flush_pend_q;
        hit_count_d        = hit_count_q;
        miss_count_d       = miss_count_q;
        install            = 1'b0;

        unique case (state_q)
            StIdle: begin
                flush_pend_d = 1'b0;
                if (fetch_read_valid) begin
                    if (req_hit) begin
                        fetch_read_data_d  = data_q[req_idx];
                        fetch_read_ready_d = 1'b1;
                        if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_ONE;
                        state_d = StRespond;
                    end else begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = fetch_read_address;
                        if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_ONE;
                        state_d = StMissWait;
                    end
                end
            end
            StMissWait: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_read_ready) begin
                    fill_data_d      = mem_read_data;
                    mem_read_valid_d = 1'b0;
                    install          = !flush_pend_q && !flush;
                    state_d          = StMissDrop;
                end
            end
            StMissDrop: begin
                if (flush) flush_pend_d = 1'b1;
                // Controller relay must complete before anything new is issued.
                if (!mem_read_ready) begin
                    flush_pend_d = 1'b0;
                    if (fetch_read_valid) begin
                        fetch_read_ready_d = 1'b1;
                        fetch_read_data_d  = fill_data_q;
                        state_d            = StRespond;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StRespond: begin
                if (!fetch_read_valid) begin
                    fetch_read_ready_d = 1'b0;
                    state_d            = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (install) begin
            valid_d[fill_idx] = 1'b1;
            tag_d[fill_idx]   = fill_tag;
            data_d[fill_idx]  = mem_read_data;
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= StIdle;
            valid_q            <= '0;
            tag_q              <= '{default: '0};
            data_q             <= '{default: '0};
            fetch_read_ready_q <= 1'b0;
            fetch_read_data_q  <= '0;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            fill_data_q        <= '0;
            flush_pend_q       <= 1'b0;
            hit_count_q        <= '0;
            miss_count_q       <= '0;
        end else begin
            state_q            <= state_d;
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            data_q             <= data_d;
            fetch_read_ready_q <= fetch_read_ready_d;
            fetch_read_data_q  <= fetch_read_data_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            fill_data_q        <= fill_data_d;
            flush_pend_q       <= flush_pend_d;
            hit_count_q        <= hit_count_d;
            miss_count_q       <= miss_count_d;
        end
    end

    assign fetch_read_ready = fetch_read_ready_q;
    assign fetch_read_data  = fetch_read_data_q;
    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign hit_count        = hit_count_q;
    assign miss_count       = miss_count_q;

endmodule
